// File: rtl/turn_ctrl_pkg.sv
// Shared definitions for the board-game turn controller: state encoding,
// track geometry and player-index helpers.
package turn_ctrl_pkg;

    localparam int NUM_TILES     = 24;
    localparam int DEF_WIN_STEPS = 24;
    localparam int PIDX_W        = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FLIP = 3'd1,
        ST_ADV       = 3'd2,
        ST_CHECK     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Player counts outside 2..4 fall back to the full table of four.
    function automatic logic [2:0] clamp_players(input logic [4:0] n);
        if (n == 5'd2 || n == 5'd3 || n == 5'd4)
            return n[2:0];
        else
            return 3'd4;
    endfunction

    function automatic logic [PIDX_W-1:0] next_player(input logic [PIDX_W-1:0] cur,
                                                      input logic [2:0] n_eff);
        logic [2:0] nx;
        nx = {1'b0, cur} + 3'd1;
        return (nx >= n_eff) ? '0 : nx[PIDX_W-1:0];
    endfunction

endpackage

// File: rtl/turn_ctrl_if.sv
// Game-flow bus between the sequencer (master) and turn_ctrl (slave).
interface turn_ctrl_if;
    import turn_ctrl_pkg::*;

    logic [4:0]        N;
    logic              start;
    logic              flip_valid;
    logic              card_match;
    logic              p_da0;
    logic              p_da1;
    logic              p_da2;
    logic              p_da3;
    logic [PIDX_W-1:0] cur_player;
    logic              turn_done;
    logic              game_over;
    logic [PIDX_W-1:0] winner;

    modport master (
        output N, start, flip_valid, card_match,
        input  p_da0, p_da1, p_da2, p_da3, cur_player, turn_done, game_over, winner
    );

    modport slave (
        input  N, start, flip_valid, card_match,
        output p_da0, p_da1, p_da2, p_da3, cur_player, turn_done, game_over, winner
    );

endinterface

// File: rtl/turn_ctrl_step_tracker.sv
// Four per-player step counters with clear, indexed increment and saturation
// at WIN_STEPS; reached_win reports the selected player's counter.
module turn_ctrl_step_tracker
    import turn_ctrl_pkg::*;
#(
    parameter int WIN_STEPS = DEF_WIN_STEPS,
    parameter int STEP_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [PIDX_W-1:0] sel,
    output logic              reached_win
);

    localparam logic [STEP_W-1:0] WIN_CNT = STEP_W'(WIN_STEPS);

    logic [STEP_W-1:0] steps [4];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < 4; i++)
                steps[i] <= '0;
        end else if (inc && steps[sel] != WIN_CNT) begin
            steps[sel] <= steps[sel] + 1'b1;
        end
    end

    assign reached_win = (steps[sel] == WIN_CNT);

endmodule

// File: rtl/turn_ctrl.sv
// Turn sequencer: rotates the active player on mismatches, issues one-cycle
// advance enables on matches and latches the first player to finish the lap.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no game; waiting for start
// WAIT_FLIP | waiting for the active player's flip result
// ADV       | match accepted; advance enable and step increment issued
// CHECK     | compare the active player's steps against WIN_STEPS
// DONE      | game decided; outputs hold until start
module turn_ctrl
    import turn_ctrl_pkg::*;
#(
    parameter int WIN_STEPS = DEF_WIN_STEPS,
    parameter int STEP_W    = 6
) (
    input  logic  B,
    input  logic  rst,
    turn_ctrl_if.slave bus
);

    state_t            state, state_nxt;
    logic [2:0]        n_eff, n_eff_nxt;
    logic [PIDX_W-1:0] cur, cur_nxt;
    logic [PIDX_W-1:0] win, win_nxt;
    logic [3:0]        p_da, p_da_nxt;
    logic              turn_done, turn_done_nxt;
    logic              game_over, game_over_nxt;
    logic              clr, inc, reached_win;

    turn_ctrl_step_tracker #(
        .WIN_STEPS (WIN_STEPS),
        .STEP_W    (STEP_W)
    ) u_steps (
        .clk         (B),
        .rst         (rst),
        .clr         (clr),
        .inc         (inc),
        .sel         (cur),
        .reached_win (reached_win)
    );

    always_ff @(posedge B) begin
        if (rst) begin
            state     <= ST_IDLE;
            n_eff     <= 3'd4;
            cur       <= '0;
            win       <= '0;
            p_da      <= '0;
            turn_done <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            n_eff     <= n_eff_nxt;
            cur       <= cur_nxt;
            win       <= win_nxt;
            p_da      <= p_da_nxt;
            turn_done <= turn_done_nxt;
            game_over <= game_over_nxt;
        end
    end

    // start overrides everything, including a flip in the same cycle.
    always_comb begin
        state_nxt     = state;
        n_eff_nxt     = n_eff;
        cur_nxt       = cur;
        win_nxt       = win;
        p_da_nxt      = '0;
        turn_done_nxt = 1'b0;
        game_over_nxt = game_over;
        clr           = 1'b0;
        inc           = 1'b0;

        if (bus.start) begin
            clr           = 1'b1;
            cur_nxt       = '0;
            win_nxt       = '0;
            game_over_nxt = 1'b0;
            n_eff_nxt     = clamp_players(bus.N);
            state_nxt     = ST_WAIT_FLIP;
        end else begin
            case (state)
                ST_WAIT_FLIP: begin
                    if (bus.flip_valid) begin
                        if (bus.card_match) begin
                            state_nxt = ST_ADV;
                        end else begin
                            cur_nxt       = next_player(cur, n_eff);
                            turn_done_nxt = 1'b1;
                        end
                    end
                end
                ST_ADV: begin
                    p_da_nxt[cur] = 1'b1;
                    inc           = 1'b1;
                    state_nxt     = ST_CHECK;
                end
                ST_CHECK: begin
                    if (reached_win) begin
                        win_nxt       = cur;
                        game_over_nxt = 1'b1;
                        state_nxt     = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT_FLIP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.p_da0      = p_da[0];
    assign bus.p_da1      = p_da[1];
    assign bus.p_da2      = p_da[2];
    assign bus.p_da3      = p_da[3];
    assign bus.cur_player = cur;
    assign bus.turn_done  = turn_done;
    assign bus.game_over  = game_over;
    assign bus.winner     = win;

endmodule

// File: tb/tb_turn_ctrl.sv
// Directed and randomized checks of turn_ctrl against a game-level model
// that tracks scheduled events by edge number.
module tb_turn_ctrl;
    import turn_ctrl_pkg::*;

    localparam int WIN = 24;

    logic B = 1'b0;
    logic rst;

    turn_ctrl_if bus ();

    turn_ctrl #(.WIN_STEPS(WIN), .STEP_W(6)) dut (
        .B   (B),
        .rst (rst),
        .bus (bus)
    );

    always #5 B = ~B;

    int vectors     = 0;
    int miscompares = 0;

    int edge_n;
    int m_n, m_cur, m_over, m_winner, m_active;
    int m_steps [4];
    int m_pulse_edge, m_check_edge, m_free_edge;
    int m_pda, m_td;

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cur        = 0;
        m_over       = 0;
        m_winner     = 0;
        m_pulse_edge = -1;
        m_check_edge = -1;
        m_free_edge  = 0;
        for (int i = 0; i < 4; i++) m_steps[i] = 0;
    endtask

    task automatic model_edge(input bit r, input bit s, input int n, input bit f, input bit m);
        m_pda = 0;
        m_td  = 0;
        if (r) begin
            model_clear();
            m_active = 0;
            m_n      = 4;
        end else if (s) begin
            model_clear();
            m_active = 1;
            m_n      = (n >= 2 && n <= 4) ? n : 4;
        end else begin
            if (m_pulse_edge == edge_n) begin
                m_pda = 1 << m_cur;
                if (m_steps[m_cur] < WIN) m_steps[m_cur]++;
            end
            if (m_check_edge == edge_n && m_steps[m_cur] == WIN) begin
                m_over   = 1;
                m_winner = m_cur;
                m_active = 0;
            end
            if (m_active != 0 && f && edge_n >= m_free_edge) begin
                if (m) begin
                    m_pulse_edge = edge_n + 1;
                    m_check_edge = edge_n + 2;
                    m_free_edge  = edge_n + 3;
                end else begin
                    m_cur = (m_cur + 1) % m_n;
                    m_td  = 1;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input int n, input bit f, input bit m);
        int pda_obs;
        @(negedge B);
        rst            = r;
        bus.start      = s;
        bus.N          = 5'(n);
        bus.flip_valid = f;
        bus.card_match = m;
        @(posedge B);
        edge_n++;
        model_edge(r, s, n, f, m);
        #1;
        pda_obs = int'({bus.p_da3, bus.p_da2, bus.p_da1, bus.p_da0});
        check_val("p_da", pda_obs, m_pda);
        check_val("cur_player", int'(bus.cur_player), m_cur);
        check_val("turn_done", int'(bus.turn_done), m_td);
        check_val("game_over", int'(bus.game_over), m_over);
        if (m_over != 0) check_val("winner", int'(bus.winner), m_winner);
    endtask

    task automatic idle(input int cycles, input int n);
        for (int i = 0; i < cycles; i++) cyc(0, 0, n, 0, 0);
    endtask

    initial begin
        edge_n   = 0;
        m_active = 0;
        m_n      = 4;
        model_clear();
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.N          = 5'd0;
        bus.flip_valid = 1'b0;
        bus.card_match = 1'b0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 3, 1, 1);
        cyc(0, 0, 3, 1, 0);
        idle(2, 3);

        // N=3 rotation by mismatches
        cyc(0, 1, 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 3, 1, 0);
            idle(1, 3);
        end

        // N=2, one match with a dropped back-to-back flip
        cyc(0, 1, 2, 0, 0);
        cyc(0, 0, 2, 1, 1);
        cyc(0, 0, 2, 1, 1);
        cyc(0, 0, 2, 1, 1);
        idle(3, 2);

        // N=4, player 0 runs the full lap
        cyc(0, 1, 4, 0, 0);
        for (int i = 0; i < WIN; i++) begin
            cyc(0, 0, 4, 1, 1);
            idle(2, 4);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 4, 1, 1);
            cyc(0, 0, 4, 1, 0);
        end
        idle(2, 4);

        // restart from DONE, then illegal N clamped to 4, N changes ignored
        cyc(0, 1, 7, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 2, 1, 0);
        cyc(0, 0, 2, 1, 1);
        idle(3, 2);

        // reset landing in ADV, then flips before start
        cyc(0, 1, 4, 0, 0);
        cyc(0, 0, 4, 1, 1);
        cyc(1, 0, 4, 0, 0);
        cyc(0, 0, 4, 1, 1);
        idle(3, 4);
        cyc(0, 0, 4, 1, 0);

        // start with simultaneous flip in WAIT_FLIP
        cyc(0, 1, 4, 0, 0);
        cyc(0, 0, 4, 1, 0);
        cyc(0, 1, 4, 1, 1);
        idle(3, 4);
        cyc(0, 1, 3, 1, 0);
        idle(2, 3);

        // randomized play
        for (int i = 0; i < 4000; i++) begin
            bit r, s, f, m;
            int n;
            r = ($urandom_range(999) < 2);
            s = ($urandom_range(999) < 4);
            f = ($urandom_range(99) < 45);
            m = ($urandom_range(99) < 75);
            n = int'($urandom_range(31));
            cyc(r, s, n, f, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
